pmem_arbiter: RTL

Shares the single 256-bit physical-memory port between the L1 instruction cache (read-only) and the L1 data cache (read/write-back). Sits between both caches' pmem-side ports and the L2/main-memory interface. It serializes whole-line transactions, routes each response only to its owner, and sequences grant/release with a small FSM.

---
 rtl/pmem_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/pmem_arbiter.sv
// Two-requester arbiter serializing I-cache and D-cache line transactions onto one pmem port.
// Build option PMEM_ARB_RR_EN selects round-robin tie-breaking; default is fixed D-over-I priority.
module pmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_pmem_address,
   input  logic              i_pmem_read,
   output logic [LINE_W-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,
   input  logic [ADDR_W-1:0] d_pmem_address,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [LINE_W-1:0] d_pmem_wdata,
   output logic [LINE_W-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,
   output logic [ADDR_W-1:0] pmem_address,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RELEASE} state_e;

   state_e state_q, state_d;
   logic   i_req, d_req, pick_d;

   assign i_req = i_pmem_read;
   assign d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_RR_EN
   // prio_d_q = 1 favours D on a tie; flips toward the other side after each completed grant.
   logic prio_d_q, prio_d_d;

   assign pick_d = d_req & (~i_req | prio_d_q);

   always_comb begin
      prio_d_d = prio_d_q;
      if (pmem_resp && state_q == GNT_D) prio_d_d = 1'b0;
      if (pmem_resp && state_q == GNT_I) prio_d_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) prio_d_q <= 1'b1;
      else      prio_d_q <= prio_d_d;
   end
`else
   assign pick_d = d_req;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (pick_d)     state_d = GNT_D;
            else if (i_req) state_d = GNT_I;
         end
         GNT_I:   if (pmem_resp) state_d = RELEASE;
         GNT_D:   if (pmem_resp) state_d = RELEASE;
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Strobes follow the requester's live level while granted, so a premature drop is forwarded as-is.
   always_comb begin
      pmem_address = '0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      i_pmem_resp  = 1'b0;
      d_pmem_resp  = 1'b0;
      unique case (state_q)
         GNT_I: begin
            pmem_address = i_pmem_address;
            pmem_read    = i_pmem_read;
            i_pmem_resp  = pmem_resp;
         end
         GNT_D: begin
            pmem_address = d_pmem_address;
            pmem_write   = d_pmem_write;
            pmem_read    = d_pmem_read & ~d_pmem_write;
            d_pmem_resp  = pmem_resp;
         end
         default: ;
      endcase
   end

   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;
   assign pmem_wdata   = d_pmem_wdata;

   a_resp_excl: assert property (@(posedge clk) disable iff (!rst) !(i_pmem_resp && d_pmem_resp));

endmodule
